sync_fifo_prog: RTL and testbench

SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

---
 rtl/fifo_pkg.sv | 30 +++
 rtl/fifo_mem.sv | 27 ++
 rtl/sync_fifo_prog.sv | 138 +++++++++++++
 tb/tb_sync_fifo_prog.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO defaults, status bundle and the width helper used to size pointers.
// Combinational only: no latency and no flow control.
// Backpressure: not applicable.
package fifo_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 32;
    localparam int AFULL_DEF  = DEPTH - 2;
    localparam int AEMPTY_DEF = 2;

    typedef struct packed {
        logic empty;
        logic almost_empty;
        logic full;
        logic almost_full;
    } fifo_status_t;

    // Smallest n with 2**n >= value; usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: one synchronous write port, one asynchronous read port.
// Write lands on the next rising edge; read data follows rd_addr combinationally.
// Backpressure: none; the caller gates wr_en.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int AW         = 5
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds and sticky error flags.
// Latency: FWFT=0 returns the head word one cycle after rd_en; FWFT=1 shows the head combinationally.
// Backpressure: writes while full without a same-cycle read are dropped and raise overflow.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int  DEPTH      = fifo_pkg::DEPTH,
    parameter int  FWFT       = 0,
    localparam int AW         = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [AW:0]           afull_thr,
    input  logic [AW:0]           aempty_thr,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic [AW:0]           count,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] head_dat;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ovf_set;
    logic                  udf_set;
    fifo_status_t          status;

    always_comb begin
        status              = '0;
        status.empty        = (count == '0);
        status.full         = (count == DEPTH_CNT);
        status.almost_full  = (count >= afull_thr);
        status.almost_empty = (count <= aempty_thr);
    end

    assign empty        = status.empty;
    assign full         = status.full;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;

    // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
    assign rd_acc  = rd_en && !status.empty;
    assign wr_acc  = wr_en && (!status.full || rd_acc);
    assign ovf_set = wr_en && status.full && !rd_acc;
    assign udf_set = rd_en && status.empty;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc && rst_n),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (head_dat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // A fresh error in the same cycle as clr_err must survive the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (udf_set) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = head_dat;
            assign valid    = !status.empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  vld_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dout_q <= '0;
                    vld_q  <= 1'b0;
                end else begin
                    vld_q <= rd_acc;
                    if (rd_acc) begin
                        dout_q <= head_dat;
                    end
                end
            end

            assign data_out = dout_q;
            assign valid    = vld_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: a registered-read instance and a FWFT instance side by side.
module tb_sync_fifo_prog;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr_err;
    logic [5:0] afull_thr;
    logic [5:0] aempty_thr;

    logic [7:0] data_in;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] data_out;
    logic       valid;
    logic [5:0] count;
    logic       empty, almost_empty, full, almost_full, overflow, underflow;

    logic [7:0] f_data_in;
    logic       f_wr_en;
    logic       f_rd_en;
    logic [7:0] f_data_out;
    logic       f_valid;
    logic [5:0] f_count;
    logic       f_empty, f_almost_empty, f_full, f_almost_full, f_overflow, f_underflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(32), .FWFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .afull_thr(afull_thr), .aempty_thr(aempty_thr), .clr_err(clr_err),
        .data_out(data_out), .valid(valid), .count(count), .empty(empty),
        .almost_empty(almost_empty), .full(full), .almost_full(almost_full),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(32), .FWFT(1)) dut_fwft (
        .clk(clk), .rst_n(rst_n), .data_in(f_data_in), .wr_en(f_wr_en), .rd_en(f_rd_en),
        .afull_thr(afull_thr), .aempty_thr(aempty_thr), .clr_err(clr_err),
        .data_out(f_data_out), .valid(f_valid), .count(f_count), .empty(f_empty),
        .almost_empty(f_almost_empty), .full(f_full), .almost_full(f_almost_full),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h99; clr_err = 1'b0;
        f_wr_en = 1'b1; f_rd_en = 1'b0; f_data_in = 8'h11;
        cyc(); cyc();
        wr_en = 1'b0; rd_en = 1'b0; f_wr_en = 1'b0;
        checks++;
        if ({count, empty, full, valid, data_out, overflow, underflow} !== {6'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b valid=%b dout=%h ovf=%b udf=%b, want 0 1 0 0 00 0 0",
                     count, empty, full, valid, data_out, overflow, underflow);
        end
        aempty_thr = 6'd0; #1;
        checks++;
        if (almost_empty !== 1'b1) begin
            errors++; $display("FAIL reset_aempty_thr0: got %b want 1", almost_empty);
        end
        aempty_thr = 6'd2;
        rst_n = 1'b1;
        cyc();
        checks++;
        if ({count, empty, f_count, f_empty, f_valid} !== {6'd0, 1'b1, 6'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_release: count=%0d empty=%b f_count=%0d f_empty=%b f_valid=%b, want 0 1 0 1 0",
                     count, empty, f_count, f_empty, f_valid);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; data_in = 8'(i);
            cyc();
            checks++;
            if (count !== 6'(i + 1) || full !== (i == 31)) begin
                errors++; $display("FAIL fill_count[%0d]: count=%0d full=%b want %0d %b", i, count, full, i + 1, (i == 31));
            end
        end
        wr_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd_en = 1'b1;
            cyc();
            checks++;
            if (valid !== 1'b1 || data_out !== 8'(i)) begin
                errors++; $display("FAIL drain_data[%0d]: valid=%b dout=%h want 1 %h", i, valid, data_out, 8'(i));
            end
        end
        rd_en = 1'b0;
        cyc();
        checks++;
        if ({valid, data_out, empty, overflow, underflow} !== {1'b0, 8'd31, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL drain_end: valid=%b dout=%h empty=%b ovf=%b udf=%b want 0 1f 1 0 0",
                     valid, data_out, empty, overflow, underflow);
        end
    endtask

    task automatic test_wrap();
        int exp_rd;
        exp_rd = 0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; data_in = 8'(i);
            cyc();
        end
        for (int i = 16; i < 56; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; data_in = 8'(i);
            cyc();
            checks++;
            if (count !== 6'd16 || valid !== 1'b1 || data_out !== 8'(exp_rd)) begin
                errors++;
                $display("FAIL wrap_simul[%0d]: count=%0d valid=%b dout=%h want 16 1 %h", i, count, valid, data_out, 8'(exp_rd));
            end
            exp_rd++;
        end
        wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            cyc();
            checks++;
            if (valid !== 1'b1 || data_out !== 8'(exp_rd)) begin
                errors++; $display("FAIL wrap_drain[%0d]: valid=%b dout=%h want 1 %h", i, valid, data_out, 8'(exp_rd));
            end
            exp_rd++;
        end
        rd_en = 1'b0;
        cyc();
        checks++;
        if (empty !== 1'b1 || exp_rd != 56) begin
            errors++; $display("FAIL wrap_end: empty=%b reads=%0d want 1 56", empty, exp_rd);
        end
    endtask

    task automatic test_thresholds();
        int cnt;
        afull_thr = 6'd0; #1;
        checks++;
        if (almost_full !== 1'b1) begin
            errors++; $display("FAIL afull_thr0: got %b want 1", almost_full);
        end
        afull_thr = 6'd30;
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; data_in = 8'(i + 64);
            cyc();
            cnt = i + 1;
            checks++;
            if ({empty, almost_empty, almost_full, full} !== {cnt == 0, cnt <= 2, cnt >= 30, cnt == 32}) begin
                errors++;
                $display("FAIL fill_flags[cnt=%0d]: e/ae/af/f=%b%b%b%b want %b%b%b%b", cnt, empty, almost_empty,
                         almost_full, full, cnt == 0, cnt <= 2, cnt >= 30, cnt == 32);
            end
            if (cnt == 12) begin
                wr_en = 1'b0;
                afull_thr = 6'd10; #1;
                checks++;
                if (almost_full !== 1'b1) begin
                    errors++; $display("FAIL afull_thr_change: got %b want 1", almost_full);
                end
                afull_thr = 6'd30; #1;
            end
        end
        wr_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd_en = 1'b1;
            cyc();
            cnt = 31 - i;
            checks++;
            if ({empty, almost_empty, almost_full, full} !== {cnt == 0, cnt <= 2, cnt >= 30, cnt == 32} ||
                data_out !== 8'(i + 64)) begin
                errors++;
                $display("FAIL drain_flags[cnt=%0d]: e/ae/af/f=%b%b%b%b dout=%h want %b%b%b%b %h", cnt, empty,
                         almost_empty, almost_full, full, data_out, cnt == 0, cnt <= 2, cnt >= 30, cnt == 32, 8'(i + 64));
            end
        end
        rd_en = 1'b0;
        cyc();
    endtask

    task automatic test_errors();
        logic [7:0] exp;
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; data_in = 8'(i);
            cyc();
        end
        data_in = 8'hEE;
        cyc();
        wr_en = 1'b0;
        checks++;
        if (overflow !== 1'b1 || count !== 6'd32 || underflow !== 1'b0) begin
            errors++; $display("FAIL overflow_set: ovf=%b count=%0d udf=%b want 1 32 0", overflow, count, underflow);
        end
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL overflow_clear: got %b want 0", overflow);
        end
        wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h77;
        cyc();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if ({overflow, underflow, count, valid, data_out} !== {1'b0, 1'b0, 6'd32, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL full_wr_rd: ovf=%b udf=%b count=%0d valid=%b dout=%h want 0 0 32 1 00",
                     overflow, underflow, count, valid, data_out);
        end
        wr_en = 1'b1; clr_err = 1'b1; data_in = 8'hDD;
        cyc();
        wr_en = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++; $display("FAIL overflow_beats_clr: got %b want 1", overflow);
        end
        cyc();
        clr_err = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd_en = 1'b1;
            cyc();
            exp = (i < 31) ? 8'(i + 1) : 8'h77;
            checks++;
            if (data_out !== exp) begin
                errors++; $display("FAIL err_drain[%0d]: dout=%h want %h", i, data_out, exp);
            end
        end
        cyc();
        rd_en = 1'b0;
        checks++;
        if ({underflow, overflow, valid, count} !== {1'b1, 1'b0, 1'b0, 6'd0}) begin
            errors++;
            $display("FAIL underflow_set: udf=%b ovf=%b valid=%b count=%0d want 1 0 0 0", underflow, overflow, valid, count);
        end
        rd_en = 1'b1; wr_en = 1'b1; data_in = 8'h3C;
        cyc();
        rd_en = 1'b0; wr_en = 1'b0;
        checks++;
        if ({count, valid, underflow} !== {6'd1, 1'b0, 1'b1}) begin
            errors++; $display("FAIL empty_wr_rd: count=%0d valid=%b udf=%b want 1 0 1", count, valid, underflow);
        end
        rd_en = 1'b1; clr_err = 1'b1;
        cyc();
        rd_en = 1'b0; clr_err = 1'b0;
        checks++;
        if ({valid, data_out, overflow, underflow, empty} !== {1'b1, 8'h3C, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL empty_wr_kept: valid=%b dout=%h ovf=%b udf=%b empty=%b want 1 3c 0 0 1",
                     valid, data_out, overflow, underflow, empty);
        end
    endtask

    task automatic test_fwft();
        f_wr_en = 1'b1; f_data_in = 8'hA5;
        cyc();
        f_wr_en = 1'b0;
        checks++;
        if (f_valid !== 1'b1 || f_data_out !== 8'hA5) begin
            errors++; $display("FAIL fwft_first: valid=%b dout=%h want 1 a5", f_valid, f_data_out);
        end
        f_wr_en = 1'b1; f_data_in = 8'h5A;
        cyc();
        f_wr_en = 1'b0;
        checks++;
        if (f_data_out !== 8'hA5 || f_count !== 6'd2) begin
            errors++; $display("FAIL fwft_hold: dout=%h count=%0d want a5 2", f_data_out, f_count);
        end
        f_rd_en = 1'b1;
        cyc();
        checks++;
        if (f_valid !== 1'b1 || f_data_out !== 8'h5A) begin
            errors++; $display("FAIL fwft_pop1: valid=%b dout=%h want 1 5a", f_valid, f_data_out);
        end
        cyc();
        f_rd_en = 1'b0;
        checks++;
        if ({f_valid, f_empty, f_full, f_almost_full, f_almost_empty, f_overflow, f_underflow} !== 7'b0100100) begin
            errors++;
            $display("FAIL fwft_last_pop: v/e/f/af/ae/ovf/udf=%b%b%b%b%b%b%b want 0100100", f_valid, f_empty,
                     f_full, f_almost_full, f_almost_empty, f_overflow, f_underflow);
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; data_in = 8'(i + 8'h40);
            cyc();
        end
        rd_en = 1'b1; data_in = 8'h51;
        cyc();
        checks++;
        if (count !== 6'd17 || valid !== 1'b1) begin
            errors++; $display("FAIL pre_reset: count=%0d valid=%b want 17 1", count, valid);
        end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
        checks++;
        if ({count, empty, valid, overflow, underflow} !== {6'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: count=%0d empty=%b valid=%b ovf=%b udf=%b want 0 1 0 0 0",
                     count, empty, valid, overflow, underflow);
        end
        wr_en = 1'b1; data_in = 8'hC1;
        cyc();
        data_in = 8'hC2;
        cyc();
        wr_en = 1'b0; rd_en = 1'b1;
        cyc();
        checks++;
        if (valid !== 1'b1 || data_out !== 8'hC1) begin
            errors++; $display("FAIL post_reset_rd1: valid=%b dout=%h want 1 c1", valid, data_out);
        end
        cyc();
        rd_en = 1'b0;
        checks++;
        if (data_out !== 8'hC2 || empty !== 1'b1) begin
            errors++; $display("FAIL post_reset_rd2: dout=%h empty=%b want c2 1", data_out, empty);
        end
    endtask

    initial begin
        rst_n = 1'b0; clr_err = 1'b0; afull_thr = 6'd30; aempty_thr = 6'd2;
        wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;
        f_wr_en = 1'b0; f_rd_en = 1'b0; f_data_in = 8'h00;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_thresholds();
        test_errors();
        test_fwft();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
